triangle_phase_decoder: RTL

- Inverse of the triangle waveform generator: takes a stream of unsigned triangle samples and recovers phase, slope direction, lock status and period in samples.
- Sits on the loopback/measurement side of the DDS → triangle → delta-sigma chain; it checks generator output or reconstructed (decimated) waveforms.
- Decoding inverts the generator's quadrant/XOR mapping exactly.

---
 rtl/triangle_pkg.sv | 27 ++
 rtl/triangle_quadrant_decode.sv | 37 +++
 rtl/triangle_phase_decoder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - shared triangle quadrant encoding and decoder state enum
// Quadrant codes match the generator so decode is an exact inverse of its mapping.
package triangle_pkg;

    localparam logic [1:0] QUAD_RISE_HI = 2'b00;
    localparam logic [1:0] QUAD_FALL_HI = 2'b01;
    localparam logic [1:0] QUAD_FALL_LO = 2'b10;
    localparam logic [1:0] QUAD_RISE_LO = 2'b11;

    typedef enum logic [1:0] {
        EMPTY,
        ACQUIRE,
        TRACK
    } state_t;

    function automatic logic [1:0] quad_of(input logic dir, input logic msb);
        logic [1:0] q;
        case ({dir, msb})
            2'b11:   q = QUAD_RISE_HI;
            2'b01:   q = QUAD_FALL_HI;
            2'b00:   q = QUAD_FALL_LO;
            default: q = QUAD_RISE_LO;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/triangle_quadrant_decode.sv
// rtl/triangle_quadrant_decode.sv - combinational (dir, wave) to phase decode
// Falling quadrants mirror the low field; the raw phase is then scaled to phaseBits.
module triangle_quadrant_decode
    import triangle_pkg::*;
#(
    parameter int phaseBits = 12,
    parameter int waveBits  = 12
) (
    input  logic                 i_dir,
    input  logic [waveBits-1:0]  i_wave,
    output logic [1:0]           o_quad,
    output logic [phaseBits-1:0] o_phase
);
    localparam int RAW_W = waveBits + 1;

    logic [waveBits-2:0] w_low;
    logic [waveBits-2:0] w_low_m;
    logic [RAW_W-1:0]    w_raw;

    assign o_quad  = quad_of(i_dir, i_wave[waveBits-1]);
    assign w_low   = i_wave[waveBits-2:0];
    assign w_low_m = ((o_quad == QUAD_FALL_HI) || (o_quad == QUAD_FALL_LO)) ? ~w_low : w_low;
    assign w_raw   = {o_quad, w_low_m};

    generate
        if (phaseBits >= RAW_W) begin : g_widen
            logic [phaseBits-1:0] w_ext;
            assign w_ext   = phaseBits'(w_raw);
            assign o_phase = w_ext << (phaseBits - RAW_W);
        end else begin : g_narrow
            logic [RAW_W-1:0] w_sh;
            assign w_sh    = w_raw >> (RAW_W - phaseBits);
            assign o_phase = w_sh[phaseBits-1:0];
        end
    endgenerate

endmodule

// File: rtl/triangle_phase_decoder.sv
// rtl/triangle_phase_decoder.sv - recovers phase, slope, lock and period from triangle samples
// One output per accepted sample once slope is known; outputs register one cycle later.
module triangle_phase_decoder
    import triangle_pkg::*;
#(
    parameter int phaseBits  = 12,
    parameter int waveBits   = 12,
    parameter int periodBits = 24,
    parameter int hyst       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [waveBits-1:0]   in_wave,
    output logic                  out_valid,
    output logic [phaseBits-1:0]  out_phase,
    output logic                  out_dir,
    output logic                  locked,
    output logic [periodBits-1:0] period,
    output logic                  period_valid
);
    localparam logic [waveBits-1:0] MID = {1'b1, {(waveBits-1){1'b0}}};
    localparam logic [waveBits-1:0] QTR = {2'b01, {(waveBits-2){1'b0}}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [waveBits-1:0]   r_prev;
    logic                  r_dir;
    logic [1:0]            r_prev_quad;
    logic [1:0]            r_wraps;
    logic [periodBits-1:0] r_cnt;
    logic                  r_out_valid;
    logic [phaseBits-1:0]  r_out_phase;
    logic                  r_locked;
    logic [periodBits-1:0] r_period;
    logic                  r_period_valid;

    logic [waveBits:0]     w_diff;
    logic [waveBits:0]     w_mag;
    logic [waveBits-1:0]   w_ofs;
    logic                  w_big;
    logic                  w_up;
    logic                  w_near_mid;
    logic                  w_emit;
    logic                  w_flip;
    logic                  w_new_dir;
    logic                  w_reversal;
    logic                  w_wrap;
    logic [1:0]            w_quad;
    logic [phaseBits-1:0]  w_phase;
    logic [periodBits-1:0] w_cnt_inc;

    assign w_diff     = {1'b0, in_wave} - {1'b0, r_prev};
    assign w_mag      = w_diff[waveBits] ? (~w_diff + 1'b1) : w_diff;
    assign w_big      = (w_mag >= (waveBits+1)'(hyst));
    assign w_up       = ~w_diff[waveBits];
    assign w_ofs      = in_wave[waveBits-1] ? (in_wave - MID) : (MID - in_wave);
    assign w_near_mid = (w_ofs < QTR);

    always_comb begin
        w_state_nxt = r_state;
        w_new_dir   = r_dir;
        w_emit      = 1'b0;
        w_flip      = 1'b0;
        if (in_valid) begin
            case (r_state)
                EMPTY: w_state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (w_big) begin
                        w_state_nxt = TRACK;
                        w_new_dir   = w_up;
                        w_emit      = 1'b1;
                    end
                end
                TRACK: begin
                    w_emit = 1'b1;
                    if (w_big && (w_up != r_dir)) begin
                        w_flip    = 1'b1;
                        w_new_dir = w_up;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    triangle_quadrant_decode #(
        .phaseBits(phaseBits),
        .waveBits (waveBits)
    ) u_quad (
        .i_dir  (w_new_dir),
        .i_wave (in_wave),
        .o_quad (w_quad),
        .o_phase(w_phase)
    );

    // A slope flip away from the peaks cannot come from a clean triangle.
    assign w_reversal = w_flip && w_near_mid;
    assign w_wrap     = (r_state == TRACK) && (r_prev_quad == QUAD_RISE_LO) && (w_quad == QUAD_RISE_HI);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev         <= '0;
            r_dir          <= 1'b0;
            r_prev_quad    <= QUAD_RISE_HI;
            r_wraps        <= '0;
            r_cnt          <= '0;
            r_out_valid    <= 1'b0;
            r_out_phase    <= '0;
            r_locked       <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_out_valid    <= w_emit;
            r_period_valid <= 1'b0;
            if (in_valid) begin
                r_prev <= in_wave;
            end
            if (w_emit) begin
                r_dir       <= w_new_dir;
                r_out_phase <= w_phase;
                r_prev_quad <= w_quad;
                if (w_reversal) begin
                    r_locked <= 1'b0;
                    r_wraps  <= '0;
                    r_cnt    <= '0;
                end else if (w_wrap) begin
                    if (r_wraps != 2'd0) begin
                        r_period       <= w_cnt_inc;
                        r_period_valid <= 1'b1;
                        r_locked       <= 1'b1;
                    end
                    if (r_wraps != 2'd2) begin
                        r_wraps <= r_wraps + 2'd1;
                    end
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_phase    = r_out_phase;
    assign out_dir      = r_dir;
    assign locked       = r_locked;
    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule
